// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding core request to APB4 master bridge
module apb_master_bridge #(
    parameter int             AW        = 32,
    parameter int             DW        = 32,
    parameter int             SLAVES    = 4,
    parameter logic [AW-1:0]  BASE_ADDR = 32'h1000_0000,
    parameter int             SEL_LSB   = 12,
    parameter int             TIMEOUT   = 255
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [AW-1:0]     req_addr_i,
    input  logic              req_write_i,
    input  logic [DW-1:0]     req_wdata_i,
    input  logic [DW/8-1:0]   req_strb_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DW-1:0]     rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [AW-1:0]     m_apb_paddr_o,
    output logic              m_apb_pwrite_o,
    output logic [SLAVES-1:0] m_apb_psel_o,
    output logic              m_apb_penable_o,
    output logic [DW-1:0]     m_apb_pwdata_o,
    output logic [DW/8-1:0]   m_apb_pstrb_o,
    input  logic              m_apb_pready_i,
    input  logic [DW-1:0]     m_apb_prdata_i
);

    localparam int IW = $clog2(SLAVES);
    localparam int SW = DW / 8;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    // One extra bit so the window limit cannot wrap at the top of the address space.
    localparam logic [AW:0] LIMIT    = {1'b0, BASE_ADDR} + ((AW+1)'(SLAVES) << SEL_LSB);
    localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]        r_state;
    logic [AW-1:0]     r_addr;
    logic              r_write;
    logic [DW-1:0]     r_wdata;
    logic [SW-1:0]     r_strb;
    logic [IW-1:0]     r_idx;
    logic [7:0]        r_cnt;
    logic [DW-1:0]     r_rdata;
    logic              r_err;

    logic              w_in_range;
    logic [IW-1:0]     w_idx;
    logic [SLAVES-1:0] w_sel_onehot;
    logic              w_bus_active;

    assign w_in_range   = ({1'b0, req_addr_i} >= {1'b0, BASE_ADDR}) && ({1'b0, req_addr_i} < LIMIT);
    assign w_idx        = req_addr_i[SEL_LSB +: IW];
    assign w_sel_onehot = {{(SLAVES-1){1'b0}}, 1'b1} << r_idx;
    assign w_bus_active = (r_state == SETUP) || (r_state == ACCESS);

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_strb  <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid_i) begin
                        r_addr  <= req_addr_i;
                        r_write <= req_write_i;
                        r_wdata <= req_wdata_i;
                        r_strb  <= req_write_i ? req_strb_i : '0;
                        r_idx   <= w_idx;
                        r_cnt   <= '0;
                        if (w_in_range) begin
                            r_state <= SETUP;
                        end else begin
                            r_rdata <= '0;
                            r_err   <= 1'b1;
                            r_state <= RESP;
                        end
                    end
                end
                SETUP: begin
                    r_cnt   <= '0;
                    r_state <= ACCESS;
                end
                ACCESS: begin
                    // pready wins over a timeout landing on the same cycle.
                    if (m_apb_pready_i) begin
                        r_rdata <= r_write ? '0 : m_apb_prdata_i;
                        r_err   <= 1'b0;
                        r_state <= RESP;
                    end else if (r_cnt == CNT_LAST) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        r_rdata <= '0;
                        r_err   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready_o     = (r_state == IDLE);
    assign rsp_valid_o     = (r_state == RESP);
    assign rsp_rdata_o     = r_rdata;
    assign rsp_err_o       = r_err;
    assign m_apb_paddr_o   = r_addr;
    assign m_apb_pwrite_o  = r_write;
    assign m_apb_pwdata_o  = r_wdata;
    assign m_apb_pstrb_o   = r_strb;
    assign m_apb_psel_o    = w_bus_active ? w_sel_onehot : '0;
    assign m_apb_penable_o = (r_state == ACCESS);

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - directed self-checking bench for apb_master_bridge
module tb_apb_master_bridge;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_write = 1'b0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_strb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] paddr;
    logic        pwrite;
    logic [3:0]  psel;
    logic        penable;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready = 1'b0;
    logic [31:0] prdata = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    apb_master_bridge dut (
        .clk_i           (clk),
        .resetn_i        (resetn),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_addr_i      (req_addr),
        .req_write_i     (req_write),
        .req_wdata_i     (req_wdata),
        .req_strb_i      (req_strb),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .rsp_rdata_o     (rsp_rdata),
        .rsp_err_o       (rsp_err),
        .m_apb_paddr_o   (paddr),
        .m_apb_pwrite_o  (pwrite),
        .m_apb_psel_o    (psel),
        .m_apb_penable_o (penable),
        .m_apb_pwdata_o  (pwdata),
        .m_apb_pstrb_o   (pstrb),
        .m_apb_pready_i  (pready),
        .m_apb_prdata_i  (prdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge while the bridge is idle; returns at the negedge after acceptance.
    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
        req_valid = 1'b1;
        req_addr  = a;
        req_write = w;
        req_wdata = d;
        req_strb  = s;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        check("taken_rsp_valid", rsp_valid, 0);
        check("taken_req_ready", req_ready, 1);
        rsp_ready = 1'b0;
    endtask

    task automatic run_long(input logic early_ready, input logic [31:0] exp_rd, input logic exp_err);
        int cnt;
        cnt = 0;
        pready = 1'b0;
        issue(32'h1000_3000, 1'b0, 32'h0, 4'h0);
        check("long_setup_psel", psel, 4'b1000);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rsp_valid) break;
            if (penable) cnt++;
            if (early_ready && cnt == 255) pready = 1'b1;
        end
        pready = 1'b0;
        check("long_access_cycles", cnt, 255);
        check("long_rsp_valid", rsp_valid, 1);
        check("long_rsp_err", rsp_err, exp_err);
        check("long_rsp_rdata", rsp_rdata, exp_rd);
        check("long_psel_drop", psel, 0);
        check("long_penable_drop", penable, 0);
        take_rsp();
    endtask

    logic [31:0] miss_addr [3];

    initial begin
        miss_addr = '{32'h2000_0000, 32'h0FFF_FFFC, 32'h1000_4000};

        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_rsp_err", rsp_err, 0);
        resetn = 1'b1;
        @(negedge clk);

        // Zero-wait write
        pready = 1'b1;
        issue(32'h1000_0004, 1'b1, 32'hDEAD_BEEF, 4'hF);
        check("wr_setup_psel", psel, 4'b0001);
        check("wr_setup_penable", penable, 0);
        check("wr_setup_paddr", paddr, 32'h1000_0004);
        check("wr_setup_pwdata", pwdata, 32'hDEAD_BEEF);
        check("wr_setup_pstrb", pstrb, 4'hF);
        check("wr_setup_pwrite", pwrite, 1);
        check("wr_setup_req_ready", req_ready, 0);
        check("wr_setup_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        check("wr_access_psel", psel, 4'b0001);
        check("wr_access_penable", penable, 1);
        check("wr_access_paddr", paddr, 32'h1000_0004);
        check("wr_access_pwdata", pwdata, 32'hDEAD_BEEF);
        check("wr_access_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        check("wr_rsp_valid", rsp_valid, 1);
        check("wr_rsp_err", rsp_err, 0);
        check("wr_rsp_rdata", rsp_rdata, 0);
        check("wr_rsp_psel", psel, 0);
        check("wr_rsp_penable", penable, 0);
        take_rsp();

        // Read with three wait states
        pready = 1'b0;
        prdata = 32'h1234_5678;
        issue(32'h1000_2010, 1'b0, 32'h0, 4'hF);
        check("rd_setup_psel", psel, 4'b0100);
        check("rd_setup_pstrb", pstrb, 0);
        check("rd_setup_pwrite", pwrite, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rd_wait_penable", penable, 1);
            check("rd_wait_psel", psel, 4'b0100);
            check("rd_wait_rsp_valid", rsp_valid, 0);
            if (i == 3) pready = 1'b1;
        end
        @(negedge clk);
        pready = 1'b0;
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
        check("rd_rsp_err", rsp_err, 0);
        take_rsp();

        // Decode misses, including both window edges
        foreach (miss_addr[k]) begin
            issue(miss_addr[k], 1'b0, 32'h0, 4'h0);
            check("miss_rsp_valid", rsp_valid, 1);
            check("miss_rsp_err", rsp_err, 1);
            check("miss_rsp_rdata", rsp_rdata, 0);
            check("miss_psel", psel, 0);
            check("miss_penable", penable, 0);
            check("miss_req_ready", req_ready, 0);
            take_rsp();
        end

        // Last word of the window is a hit
        pready = 1'b1;
        prdata = 32'hA5A5_0F0F;
        issue(32'h1000_3FFC, 1'b0, 32'h0, 4'h0);
        check("edge_setup_psel", psel, 4'b1000);
        @(negedge clk);
        @(negedge clk);
        check("edge_rsp_rdata", rsp_rdata, 32'hA5A5_0F0F);
        check("edge_rsp_err", rsp_err, 0);
        take_rsp();

        // Timeout abort, then pready arriving on the final allowed cycle
        prdata = 32'hCAFE_0001;
        run_long(1'b0, 32'h0, 1'b1);
        run_long(1'b1, 32'hCAFE_0001, 1'b0);

        // Response backpressure with a new request pending
        pready = 1'b1;
        issue(32'h1000_1008, 1'b1, 32'h1111_2222, 4'h3);
        @(negedge clk);
        @(negedge clk);
        prdata    = 32'h0000_55AA;
        req_valid = 1'b1;
        req_addr  = 32'h1000_0000;
        req_write = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_req_ready", req_ready, 0);
            check("bp_rsp_err", rsp_err, 0);
            check("bp_rsp_rdata", rsp_rdata, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_idle_req_ready", req_ready, 1);
        check("bp_idle_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        req_valid = 1'b0;
        check("bp_next_setup_psel", psel, 4'b0001);
        check("bp_next_pwrite", pwrite, 0);
        @(negedge clk);
        @(negedge clk);
        check("bp_next_rsp_rdata", rsp_rdata, 32'h0000_55AA);
        take_rsp();

        // Asynchronous reset mid-ACCESS
        pready = 1'b0;
        issue(32'h1000_1000, 1'b1, 32'h7777_8888, 4'hF);
        @(negedge clk);
        check("rst_mid_penable_before", penable, 1);
        #2 resetn = 1'b0;
        #1;
        check("rst_mid_psel", psel, 0);
        check("rst_mid_penable", penable, 0);
        check("rst_mid_rsp_valid", rsp_valid, 0);
        check("rst_mid_req_ready", req_ready, 1);
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_after_no_rsp", rsp_valid, 0);
        end
        pready = 1'b1;
        prdata = 32'h0BAD_F00D;
        issue(32'h1000_0010, 1'b0, 32'h0, 4'h0);
        check("rst_after_psel", psel, 4'b0001);
        @(negedge clk);
        @(negedge clk);
        check("rst_after_rsp_valid", rsp_valid, 1);
        check("rst_after_rdata", rsp_rdata, 32'h0BAD_F00D);
        take_rsp();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
